// File: rtl/perf_counter_unit.sv
// Eight saturating 32-bit performance counters gated by a COUNT/HALTED FSM,
// with a registered 16-bit half-word read port.
module perf_counter_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        halt,
    input  logic        reg_write,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic        icache_req,
    input  logic        icache_hit,
    input  logic        dcache_req,
    input  logic        dcache_hit,
    input  logic [2:0]  rd_sel,
    input  logic        rd_hi,
    output logic [15:0] rd_data,
    output logic [7:0]  ovf,
    output logic        halted
);

    typedef enum logic {
        COUNT,
        HALTED
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [31:0] cnt [8];
    logic [7:0]  events;
    logic        count_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= COUNT;
        end else begin
            state <= next_state;
        end
    end

    // clr always wins over halt, and the clr cycle itself is never counted.
    always_comb begin
        next_state = state;
        count_en   = 1'b0;
        events     = {mem_write, mem_read, dcache_hit, dcache_req,
                      icache_hit, icache_req, halt | reg_write | mem_write, 1'b1};
        if (clr) begin
            next_state = COUNT;
        end else if (state == COUNT) begin
            count_en = 1'b1;
            if (halt) begin
                next_state = HALTED;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < 8; i++) begin
                cnt[i] <= '0;
            end
            ovf <= '0;
        end else if (count_en) begin
            for (int i = 0; i < 8; i++) begin
                if (events[i]) begin
                    if (cnt[i] == 32'hFFFF_FFFF) begin
                        ovf[i] <= 1'b1;
                    end else begin
                        cnt[i] <= cnt[i] + 32'd1;
                    end
                end
            end
        end
    end

    // Reads sample the counter before this edge's increment lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_hi) begin
            rd_data <= cnt[rd_sel][31:16];
        end else begin
            rd_data <= cnt[rd_sel][15:0];
        end
    end

    assign halted = (state == HALTED);

endmodule

// File: tb/tb_perf_counter_unit.sv
// Directed self-checking bench for perf_counter_unit: reset, event counting,
// halt freeze, clr/halt priority, saturation and reset-over-everything.
module tb_perf_counter_unit;

    localparam logic [9:0] RST   = 10'h200;
    localparam logic [9:0] CLR   = 10'h100;
    localparam logic [9:0] HALT  = 10'h080;
    localparam logic [9:0] REGW  = 10'h040;
    localparam logic [9:0] MEMW  = 10'h020;
    localparam logic [9:0] IHIT  = 10'h004;
    localparam logic [9:0] ALLEV = 10'h0FF;

    logic        clk = 1'b0;
    logic        rst, clr, halt, reg_write, mem_write, mem_read;
    logic        icache_req, icache_hit, dcache_req, dcache_hit;
    logic [2:0]  rd_sel;
    logic        rd_hi;
    logic [15:0] rd_data;
    logic [7:0]  ovf;
    logic        halted;

    int passCount  = 0;
    int checkCount = 0;

    perf_counter_unit dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .halt       (halt),
        .reg_write  (reg_write),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .icache_req (icache_req),
        .icache_hit (icache_hit),
        .dcache_req (dcache_req),
        .dcache_hit (dcache_hit),
        .rd_sel     (rd_sel),
        .rd_hi      (rd_hi),
        .rd_data    (rd_data),
        .ovf        (ovf),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    // Drive {rst, clr, halt, reg_write, mem_write, mem_read,
    // icache_req, icache_hit, dcache_req, dcache_hit} for n cycles.
    task automatic applyStimulus(input logic [9:0] v, input int n);
        {rst, clr, halt, reg_write, mem_write, mem_read,
         icache_req, icache_hit, dcache_req, dcache_hit} = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    // One idle cycle with a new read address, then compare the registered data.
    task automatic readCheck(input string tag, input logic [2:0] sel, input logic hi,
                             input logic [15:0] expected);
        rd_sel = sel;
        rd_hi  = hi;
        applyStimulus(10'h000, 1);
        checkOutput(tag, {16'h0, rd_data}, {16'h0, expected});
    endtask

    initial begin
        rd_sel = 3'd0;
        rd_hi  = 1'b0;
        applyStimulus(RST, 2);
        checkOutput("reset_rd_data", {16'h0, rd_data}, 32'h0);
        checkOutput("reset_ovf", {24'h0, ovf}, 32'h0);
        checkOutput("reset_halted", {31'h0, halted}, 32'h0);

        applyStimulus(10'h000, 10);
        readCheck("idle_cycles", 3'd0, 1'b0, 16'd10);
        checkOutput("idle_ovf", {24'h0, ovf}, 32'h0);
        checkOutput("idle_halted", {31'h0, halted}, 32'h0);

        applyStimulus(REGW | MEMW, 3);
        readCheck("instr_once_per_cycle", 3'd1, 1'b0, 16'd3);
        readCheck("stores", 3'd7, 1'b0, 16'd3);
        readCheck("loads_zero", 3'd6, 1'b0, 16'd0);
        readCheck("cycles_running", 3'd0, 1'b0, 16'd17);

        applyStimulus(RST, 1);
        applyStimulus(10'h000, 4);
        checkOutput("pre_halt_halted", {31'h0, halted}, 32'h0);
        applyStimulus(HALT | REGW, 1);
        checkOutput("halt_entered", {31'h0, halted}, 32'h1);
        applyStimulus(ALLEV, 20);
        readCheck("halt_cycles_frozen", 3'd0, 1'b0, 16'd5);
        readCheck("halt_instr_counted", 3'd1, 1'b0, 16'd1);
        readCheck("halt_icache_ignored", 3'd2, 1'b0, 16'd0);
        readCheck("halt_stores_ignored", 3'd7, 1'b0, 16'd0);
        checkOutput("halt_still_halted", {31'h0, halted}, 32'h1);
        checkOutput("halt_ovf", {24'h0, ovf}, 32'h0);

        applyStimulus(CLR | HALT, 1);
        checkOutput("clr_wins_halted", {31'h0, halted}, 32'h0);
        checkOutput("clr_wins_ovf", {24'h0, ovf}, 32'h0);
        readCheck("clr_cycle_uncounted", 3'd0, 1'b0, 16'd0);
        readCheck("counting_resumed", 3'd0, 1'b0, 16'd1);
        readCheck("clr_instr_zero", 3'd1, 1'b0, 16'd0);

        dut.cnt[3] = 32'hFFFF_FFFE;
        applyStimulus(IHIT, 1);
        checkOutput("reach_max_no_ovf", {24'h0, ovf}, 32'h0);
        applyStimulus(IHIT, 2);
        checkOutput("saturate_ovf", {24'h0, ovf}, 32'h0000_0008);
        readCheck("saturate_hi", 3'd3, 1'b1, 16'hFFFF);
        readCheck("saturate_lo", 3'd3, 1'b0, 16'hFFFF);
        readCheck("icache_req_untouched", 3'd2, 1'b0, 16'd0);
        checkOutput("ovf_sticky", {24'h0, ovf}, 32'h0000_0008);

        applyStimulus(RST | CLR | ALLEV, 1);
        checkOutput("rst_priority_rd_data", {16'h0, rd_data}, 32'h0);
        checkOutput("rst_priority_ovf", {24'h0, ovf}, 32'h0);
        checkOutput("rst_priority_halted", {31'h0, halted}, 32'h0);
        applyStimulus(10'h000, 1);
        readCheck("first_post_reset_cycle", 3'd0, 1'b0, 16'd1);
        readCheck("rst_cleared_counter", 3'd3, 1'b0, 16'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/perf_counter_unit.md
PERF_COUNTER_UNIT -- requirements
Module: perf_counter_unit

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-003 SHALL have port clr  input  1  synchronous counter clear.
REQ-004 SHALL have port halt  input  1  halt committed this cycle.
REQ-005 SHALL have port reg_write  input  1  register write committed this cycle.
REQ-006 SHALL have port mem_write  input  1  store committed this cycle.
REQ-007 SHALL have port mem_read  input  1  load committed this cycle.
REQ-008 SHALL have port icache_req  input  1  valid instruction-cache request.
REQ-009 SHALL have port icache_hit  input  1  valid instruction-cache hit.
REQ-010 SHALL have port dcache_req  input  1  valid data-cache request.
REQ-011 SHALL have port dcache_hit  input  1  valid data-cache hit.
REQ-012 SHALL have port rd_sel  input  3  counter index to read.
REQ-013 SHALL have port rd_hi  input  1  1 = read bits [31:16], 0 = bits [15:0].
REQ-014 SHALL have port rd_data  output  16  registered read data.
REQ-015 SHALL have port ovf  output  8  sticky saturation flag, one per counter.
REQ-016 SHALL have port halted  output  1  high while in HALTED state.

Function
REQ-017 SHALL hold eight 32-bit counters: 0 cycles, 1 instructions, 2 icache_req, 3 icache_hit, 4 dcache_req, 5 dcache_hit, 6 loads, 7 stores.
REQ-018 SHALL use a two-state FSM: COUNT, HALTED.
REQ-019 In COUNT, counter 0 SHALL increment every cycle.
REQ-020 In COUNT, counter 1 SHALL increment by exactly 1 when (halt | reg_write | mem_write), regardless of how many of the three are high.
REQ-021 In COUNT, counters 2-7 SHALL each increment by 1 when icache_req, icache_hit, dcache_req, dcache_hit, mem_read, mem_write respectively is high.
REQ-022 COUNT->HALTED SHALL occur on halt=1; events in the halt cycle SHALL still be counted.
REQ-023 In HALTED, all counters SHALL hold, and all event inputs, including halt, SHALL be ignored.
REQ-024 HALTED->COUNT SHALL occur only on clr=1 or rst=1.
REQ-025 clr=1 SHALL zero all counters and ovf and enter COUNT next cycle; the clr cycle SHALL NOT be counted.
REQ-026 clr and halt high together: clr SHALL win; state COUNT, counters 0.
REQ-027 Counters SHALL saturate at 0xFFFF_FFFF (no wrap); an increment attempted at saturation SHALL set the counter's ovf bit, sticky until clr/rst.
REQ-028 rd_data SHALL equal the selected half of counter[rd_sel] as of the previous edge, sampled with rd_sel/rd_hi of the previous cycle (1-cycle latency).
REQ-029 Read SHALL NOT disturb counting; it SHALL return the pre-increment value when read and increment coincide.
REQ-030 rd_data SHALL return the last value of a frozen counter in HALTED.
REQ-031 halted SHALL be a direct registered decode of the FSM state.

Reset
REQ-032 rst=1 SHALL, at the next edge, zero all counters, ovf, and rd_data; clear halted; and enter COUNT.
REQ-033 rst SHALL take priority over clr and every event input, including mid-operation and in HALTED.
REQ-034 The rst cycle SHALL NOT be counted.

Verification
REQ-035 Reset, then 10 idle cycles, then rd_sel=0, rd_hi=0 -> rd_data=10 one cycle later; ovf=0, halted=0.
REQ-036 reg_write=1 and mem_write=1 in the same cycle, 3 times -> counter1=3, counter7=3, counter6=0.
REQ-037 halt=1 with reg_write=1 in cycle 5, followed by 20 events -> counter1 frozen including the halt cycle; halted=1; counter0=5 after reset, with cycles numbered from 1; all counters unchanged.
REQ-038 Force counter3 to 0xFFFF_FFFE with icache_hit high for 3 cycles -> counter3=0xFFFF_FFFF, ovf[3]=1; rd_hi=1 reads 0xFFFF.
REQ-039 In HALTED, clr=1 and halt=1 together -> next cycle halted=0, all counters 0, ovf=0, counting resumes.
REQ-040 rst asserted while clr=1 and events are active -> all outputs 0 next cycle; the first post-reset cycle yields counter0=1.
